// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000-style bus initiator: FSM state encoding,
// strobe polarity and R/W levels as seen on the bus pins.
package m68k_bus_pkg;

   // 3-bit state encoding
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_SETUP      = 3'd1;
   localparam logic [2:0] ST_STROBE     = 3'd2;
   localparam logic [2:0] ST_WAIT_DTACK = 3'd3;
   localparam logic [2:0] ST_RELEASE    = 3'd4;
   localparam logic [2:0] ST_RECOVER    = 3'd5;

   typedef enum logic [2:0] {
      StIdle      = ST_IDLE,
      StSetup     = ST_SETUP,
      StStrobe    = ST_STROBE,
      StWaitDtack = ST_WAIT_DTACK,
      StRelease   = ST_RELEASE,
      StRecover   = ST_RECOVER
   } bus_state_e;

   // Strobes are active-low on the bus
   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/m68k_bus_master.sv
// 68000-style bus initiator. Converts a one-shot request into a full
// AS/UDS/LDS/RW/DTACK cycle; one outstanding cycle at a time.
// Optional feature: define BUS_TIMEOUT_EN to abort a cycle with an ERR pulse
// after TIMEOUT_CYCLES clocks without DTACK.
module m68k_bus_master
   import m68k_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned SETUP_CYCLES   = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ,
   input  logic        REQ_RW,
   input  logic [22:0] REQ_ADDR,
   input  logic [15:0] REQ_WDATA,
   input  logic        REQ_UDS,
   input  logic        REQ_LDS,
   output logic        BUSY,
   output logic        ACK,
   output logic        ERR,
   output logic [15:0] RDATA,
   output logic [22:0] ADDR_OUT,
   output logic [15:0] DATA_OUT,
   output logic        DATA_OE,
   input  logic [15:0] DATA_IN,
   output logic        AS,
   output logic        UDS,
   output logic        LDS,
   output logic        RW,
   input  logic        DTACK
);

   // Parameter range guards, evaluated at elaboration
   if (SETUP_CYCLES < 1 || SETUP_CYCLES > 3) begin : g_bad_setup
      $error("SETUP_CYCLES must be 1..3");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be 1..255");
   end

   localparam logic [1:0] SETUP_LAST = 2'(SETUP_CYCLES - 1);

   bus_state_e state_q;
   logic [1:0] setup_cnt_q;
   logic       uds_sel_q;
   logic       lds_sel_q;

`ifdef BUS_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_cnt_q;
   logic       timed_out_q;
`endif

   // Bus-cycle FSM; every output is a register updated here
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= StIdle;
         setup_cnt_q <= 2'd0;
         uds_sel_q   <= STROBE_OFF;
         lds_sel_q   <= STROBE_OFF;
         BUSY        <= 1'b0;
         ACK         <= 1'b0;
         ERR         <= 1'b0;
         RDATA       <= 16'h0000;
         ADDR_OUT    <= 23'h000000;
         DATA_OUT    <= 16'h0000;
         DATA_OE     <= 1'b0;
         AS          <= STROBE_OFF;
         UDS         <= STROBE_OFF;
         LDS         <= STROBE_OFF;
         RW          <= RW_READ;
`ifdef BUS_TIMEOUT_EN
         tmo_cnt_q   <= 8'd0;
         timed_out_q <= 1'b0;
`endif
      end else begin
         ACK <= 1'b0;
         ERR <= 1'b0;
         case (state_q)
            StIdle: begin
               if (REQ) begin
                  if (REQ_UDS == STROBE_OFF && REQ_LDS == STROBE_OFF) begin
                     // No byte lane selected: reject without touching the bus
                     ERR <= 1'b1;
                  end else begin
                     ADDR_OUT    <= REQ_ADDR;
                     DATA_OUT    <= REQ_WDATA;
                     RW          <= REQ_RW;
                     uds_sel_q   <= REQ_UDS;
                     lds_sel_q   <= REQ_LDS;
                     setup_cnt_q <= 2'd0;
                     BUSY        <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                     timed_out_q <= 1'b0;
`endif
                     state_q     <= StSetup;
                  end
               end
            end
            StSetup: begin
               if (setup_cnt_q == SETUP_LAST) begin
                  AS <= STROBE_ON;
                  if (RW == RW_READ) begin
                     UDS <= uds_sel_q;
                     LDS <= lds_sel_q;
                  end else begin
                     DATA_OE <= 1'b1;
                  end
                  state_q <= StStrobe;
               end else begin
                  setup_cnt_q <= setup_cnt_q + 2'd1;
               end
            end
            StStrobe: begin
               // Write data strobes trail AS by one clock so data is settled
               if (RW == RW_WRITE) begin
                  UDS <= uds_sel_q;
                  LDS <= lds_sel_q;
               end
`ifdef BUS_TIMEOUT_EN
               tmo_cnt_q <= 8'd0;
`endif
               state_q <= StWaitDtack;
            end
            StWaitDtack: begin
               if (DTACK == STROBE_ON) begin
                  if (RW == RW_READ) begin
                     RDATA <= DATA_IN;
                  end
                  state_q <= StRelease;
`ifdef BUS_TIMEOUT_EN
               end else if (tmo_cnt_q == TMO_LAST) begin
                  timed_out_q <= 1'b1;
                  state_q     <= StRelease;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
               end
            end
            StRelease: begin
               AS      <= STROBE_OFF;
               UDS     <= STROBE_OFF;
               LDS     <= STROBE_OFF;
               DATA_OE <= 1'b0;
               RW      <= RW_READ;
`ifdef BUS_TIMEOUT_EN
               if (timed_out_q) begin
                  ERR <= 1'b1;
               end else begin
                  ACK <= 1'b1;
               end
`else
               ACK     <= 1'b1;
`endif
               state_q <= StRecover;
            end
            StRecover: begin
               // Responder must drop DTACK before the next cycle may begin
               if (DTACK == STROBE_OFF) begin
                  BUSY    <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master. Timeout scenario is checked when the
// bench is built with BUS_TIMEOUT_EN; otherwise the indefinite wait is checked.
module tb_m68k_bus_master;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ;
   logic        REQ_RW;
   logic [22:0] REQ_ADDR;
   logic [15:0] REQ_WDATA;
   logic        REQ_UDS;
   logic        REQ_LDS;
   logic        BUSY;
   logic        ACK;
   logic        ERR;
   logic [15:0] RDATA;
   logic [22:0] ADDR_OUT;
   logic [15:0] DATA_OUT;
   logic        DATA_OE;
   logic [15:0] DATA_IN;
   logic        AS;
   logic        UDS;
   logic        LDS;
   logic        RW;
   logic        DTACK;

   int passed = 0;
   int total  = 0;

   // Responder model and event tallies
   int dt_after;   // AS-low samples before DTACK asserts (-1 = never)
   int dt_hold;    // samples DTACK stays low after AS rises
   int as_low;
   int hold_cnt;
   int cyc;
   int ack_cnt;
   int err_cnt;
   int both_cnt;
   int as_cnt;
   int ack_at;
   int err_at;

   m68k_bus_master #(
      .TIMEOUT_CYCLES(16),
      .SETUP_CYCLES  (1)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .REQ      (REQ),
      .REQ_RW   (REQ_RW),
      .REQ_ADDR (REQ_ADDR),
      .REQ_WDATA(REQ_WDATA),
      .REQ_UDS  (REQ_UDS),
      .REQ_LDS  (REQ_LDS),
      .BUSY     (BUSY),
      .ACK      (ACK),
      .ERR      (ERR),
      .RDATA    (RDATA),
      .ADDR_OUT (ADDR_OUT),
      .DATA_OUT (DATA_OUT),
      .DATA_OE  (DATA_OE),
      .DATA_IN  (DATA_IN),
      .AS       (AS),
      .UDS      (UDS),
      .LDS      (LDS),
      .RW       (RW),
      .DTACK    (DTACK)
   );

   always #5 CLK = ~CLK;

   task automatic clear_counts();
      cyc      = 0;
      ack_cnt  = 0;
      err_cnt  = 0;
      both_cnt = 0;
      as_cnt   = 0;
      ack_at   = -1;
      err_at   = -1;
      as_low   = 0;
      hold_cnt = 0;
   endtask

   // One clock: sample just after the edge, then update the responder
   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
      if (ACK) begin
         ack_cnt++;
         if (ack_at < 0) ack_at = cyc;
      end
      if (ERR) begin
         err_cnt++;
         if (err_at < 0) err_at = cyc;
      end
      if (ACK && ERR) both_cnt++;
      if (AS == 1'b0) begin
         as_cnt++;
         as_low++;
         if (dt_after >= 0 && as_low >= dt_after) DTACK = 1'b0;
      end else begin
         as_low = 0;
         if (DTACK == 1'b0) begin
            if (hold_cnt >= dt_hold) begin
               DTACK    = 1'b1;
               hold_cnt = 0;
            end else begin
               hold_cnt++;
            end
         end
      end
   endtask

   task automatic run_until_idle();
      for (int i = 0; i < 30 && BUSY; i++) step();
   endtask

   task automatic test_reset();
      RST = 1'b1; REQ = 1'b0; REQ_RW = 1'b1; REQ_ADDR = '0; REQ_WDATA = '0;
      REQ_UDS = 1'b1; REQ_LDS = 1'b1; DATA_IN = '0; DTACK = 1'b1;
      dt_after = -1; dt_hold = 0;
      clear_counts();
      @(posedge CLK); @(posedge CLK); #1;
      total++;
      if ({AS, UDS, LDS, RW, DATA_OE, ACK, ERR, BUSY} !== 8'b1111_0000)
         $display("FAIL reset_ctrl: got %b want 11110000",
                  {AS, UDS, LDS, RW, DATA_OE, ACK, ERR, BUSY});
      else passed++;
      total++;
      if ({ADDR_OUT, DATA_OUT, RDATA} !== 55'h0)
         $display("FAIL reset_data: got addr %h dout %h rdata %h want 0", ADDR_OUT, DATA_OUT, RDATA);
      else passed++;
      RST = 1'b0;
      step();
   endtask

   task automatic test_read();
      clear_counts();
      dt_after = 2; dt_hold = 0;
      REQ = 1'b1; REQ_RW = 1'b1; REQ_ADDR = 23'h000100; REQ_UDS = 1'b0; REQ_LDS = 1'b0;
      DATA_IN = 16'hBEEF;
      step();
      REQ = 1'b0;
      total++;
      if ({BUSY, AS, RW} !== 3'b111 || ADDR_OUT !== 23'h000100)
         $display("FAIL read_setup: got busy/as/rw %b addr %h want 111 000100",
                  {BUSY, AS, RW}, ADDR_OUT);
      else passed++;
      step();
      total++;
      if ({AS, UDS, LDS} !== 3'b000)
         $display("FAIL read_strobes: got %b want 000", {AS, UDS, LDS});
      else passed++;
      run_until_idle();
      total++;
      if (ack_at !== 5) $display("FAIL read_latency: got ack at %0d want 5", ack_at);
      else passed++;
      total++;
      if (as_cnt !== 3 || ack_cnt !== 1 || err_cnt !== 0)
         $display("FAIL read_counts: got as_low %0d ack %0d err %0d want 3 1 0",
                  as_cnt, ack_cnt, err_cnt);
      else passed++;
      total++;
      if (RDATA !== 16'hBEEF || BUSY !== 1'b0)
         $display("FAIL read_data: got rdata %h busy %b want beef 0", RDATA, BUSY);
      else passed++;
   endtask

   task automatic test_write();
      clear_counts();
      dt_after = 2; dt_hold = 0;
      REQ = 1'b1; REQ_RW = 1'b0; REQ_ADDR = 23'h000200; REQ_WDATA = 16'h1234;
      REQ_UDS = 1'b1; REQ_LDS = 1'b0; DATA_IN = 16'h5555;
      step();
      REQ = 1'b0;
      total++;
      if ({RW, DATA_OE, AS} !== 3'b001 || DATA_OUT !== 16'h1234 || ADDR_OUT !== 23'h000200)
         $display("FAIL write_setup: got rw/oe/as %b dout %h addr %h want 001 1234 000200",
                  {RW, DATA_OE, AS}, DATA_OUT, ADDR_OUT);
      else passed++;
      step();
      total++;
      if ({AS, UDS, LDS, DATA_OE} !== 4'b0111)
         $display("FAIL write_as_first: got %b want 0111", {AS, UDS, LDS, DATA_OE});
      else passed++;
      step();
      total++;
      if ({AS, UDS, LDS, DATA_OE} !== 4'b0101)
         $display("FAIL write_lds: got %b want 0101", {AS, UDS, LDS, DATA_OE});
      else passed++;
      step();
      step();
      total++;
      if ({AS, UDS, LDS, DATA_OE, RW, ACK} !== 6'b111011)
         $display("FAIL write_release: got %b want 111011", {AS, UDS, LDS, DATA_OE, RW, ACK});
      else passed++;
      run_until_idle();
      total++;
      if (ack_cnt !== 1 || err_cnt !== 0 || RDATA !== 16'hBEEF || BUSY !== 1'b0)
         $display("FAIL write_done: got ack %0d err %0d rdata %h busy %b want 1 0 beef 0",
                  ack_cnt, err_cnt, RDATA, BUSY);
      else passed++;
   endtask

   task automatic test_invalid();
      clear_counts();
      dt_after = 0; dt_hold = 0;
      REQ = 1'b1; REQ_RW = 1'b1; REQ_ADDR = 23'h000777; REQ_UDS = 1'b1; REQ_LDS = 1'b1;
      step();
      REQ = 1'b0;
      total++;
      if ({ERR, BUSY, AS} !== 3'b101)
         $display("FAIL invalid_err: got err/busy/as %b want 101", {ERR, BUSY, AS});
      else passed++;
      for (int i = 0; i < 4; i++) step();
      total++;
      if (err_cnt !== 1 || as_cnt !== 0 || BUSY !== 1'b0 || ADDR_OUT !== 23'h000200)
         $display("FAIL invalid_quiet: got err %0d as_low %0d busy %b addr %h want 1 0 0 000200",
                  err_cnt, as_cnt, BUSY, ADDR_OUT);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int bad;
      clear_counts();
      dt_after = 1; dt_hold = 3;
      REQ = 1'b1; REQ_RW = 1'b1; REQ_ADDR = 23'h000300; REQ_UDS = 1'b0; REQ_LDS = 1'b0;
      DATA_IN = 16'h1111;
      for (int i = 0; i < 5; i++) step();
      total++;
      if ({ACK, AS, DTACK} !== 3'b110)
         $display("FAIL b2b_ack: got ack/as/dtack %b want 110", {ACK, AS, DTACK});
      else passed++;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (!(BUSY && AS)) bad++;
      end
      total++;
      if (bad !== 0) $display("FAIL b2b_recover_busy: got %0d bad clocks want 0", bad);
      else passed++;
      DATA_IN = 16'h2222;
      dt_hold = 0;
      step();
      total++;
      if ({BUSY, AS} !== 2'b01)
         $display("FAIL b2b_idle: got busy/as %b want 01", {BUSY, AS});
      else passed++;
      step();
      REQ = 1'b0;
      total++;
      if ({BUSY, AS} !== 2'b11)
         $display("FAIL b2b_restart: got busy/as %b want 11", {BUSY, AS});
      else passed++;
      step();
      total++;
      if (AS !== 1'b0) $display("FAIL b2b_second_as: got %b want 0", AS);
      else passed++;
      run_until_idle();
      total++;
      if (ack_cnt !== 2 || both_cnt !== 0 || RDATA !== 16'h2222)
         $display("FAIL b2b_done: got ack %0d both %0d rdata %h want 2 0 2222",
                  ack_cnt, both_cnt, RDATA);
      else passed++;
   endtask

   task automatic test_wait();
      clear_counts();
      dt_after = -1; dt_hold = 0;
      REQ = 1'b1; REQ_RW = 1'b1; REQ_ADDR = 23'h000400; REQ_UDS = 1'b0; REQ_LDS = 1'b1;
      DATA_IN = 16'hCAFE;
      step();
      REQ = 1'b0;
      for (int i = 0; i < 39; i++) step();
`ifdef BUS_TIMEOUT_EN
      total++;
      if (err_at !== 20 || ack_cnt !== 0 || err_cnt !== 1)
         $display("FAIL timeout_err: got err at %0d ack %0d err %0d want 20 0 1",
                  err_at, ack_cnt, err_cnt);
      else passed++;
      total++;
      if ({BUSY, AS, UDS, LDS, DATA_OE} !== 5'b01110 || RDATA !== 16'h2222)
         $display("FAIL timeout_release: got %b rdata %h want 01110 2222",
                  {BUSY, AS, UDS, LDS, DATA_OE}, RDATA);
      else passed++;
`else
      total++;
      if ({BUSY, AS, UDS} !== 3'b100 || err_cnt !== 0 || ack_cnt !== 0)
         $display("FAIL wait_hold: got busy/as/uds %b err %0d ack %0d want 100 0 0",
                  {BUSY, AS, UDS}, err_cnt, ack_cnt);
      else passed++;
      dt_after = 0;
      DTACK = 1'b0;
      run_until_idle();
      total++;
      if (ack_cnt !== 1 || RDATA !== 16'hCAFE || BUSY !== 1'b0)
         $display("FAIL wait_done: got ack %0d rdata %h busy %b want 1 cafe 0",
                  ack_cnt, RDATA, BUSY);
      else passed++;
`endif
   endtask

   task automatic test_reset_mid();
      clear_counts();
      dt_after = -1; dt_hold = 0;
      REQ = 1'b1; REQ_RW = 1'b0; REQ_ADDR = 23'h000500; REQ_WDATA = 16'hA5A5;
      REQ_UDS = 1'b0; REQ_LDS = 1'b0;
      step();
      REQ = 1'b0;
      step();
      step();
      total++;
      if ({AS, UDS, LDS, DATA_OE} !== 4'b0001)
         $display("FAIL rstmid_pre: got %b want 0001", {AS, UDS, LDS, DATA_OE});
      else passed++;
      #2;
      RST = 1'b1;
      #1;
      total++;
      if ({AS, UDS, LDS, DATA_OE, BUSY, RW} !== 6'b111001)
         $display("FAIL rstmid_async: got %b want 111001", {AS, UDS, LDS, DATA_OE, BUSY, RW});
      else passed++;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      clear_counts();
      dt_after = 1;
      REQ = 1'b1; REQ_RW = 1'b1; REQ_ADDR = 23'h000600; REQ_UDS = 1'b0; REQ_LDS = 1'b0;
      DATA_IN = 16'h0F0F;
      step();
      REQ = 1'b0;
      run_until_idle();
      total++;
      if (ack_cnt !== 1 || RDATA !== 16'h0F0F || ADDR_OUT !== 23'h000600 || BUSY !== 1'b0)
         $display("FAIL rstmid_next: got ack %0d rdata %h addr %h busy %b want 1 0f0f 000600 0",
                  ack_cnt, RDATA, ADDR_OUT, BUSY);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_invalid();
      test_back_to_back();
      test_wait();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
